spi_flash_responder: RTL
========================

// Module: spi_flash_responder
// PURPOSE
//  SPI-flash responder (mode 0, MSB-first): the device end of the flash XIP read path on the SPI bus.
//  Oversamples SCK/SS/MOSI in the system clock domain, decodes READ (cmd 0x03 + 24-bit address).
//  Fetches 32-bit words through a req/ack memory port and shifts them out on MISO.
//  Streams continuously with address auto-increment and one-word prefetch while SS stays low.
// PARAMETERS
//  SYNC_STAGES  2      synchronizer flops on spi_sck/spi_ss/spi_mosi (>=2)
//  CMD_READ     8'h03  opcode answered; any other opcode is ignored
//  ADDR_W       24     flash address width; address wraps modulo 2**ADDR_W
// PORTS
//  clock      in   1   system clock; all logic on posedge
//  reset      in   1   asynchronous, active-low reset (asserts immediately, deassert sync'd externally)
//  spi_sck    in   1   SPI clock from master, idle low
//  spi_ss     in   1   chip select, active-low
//  spi_mosi   in   1   master-out data
//  spi_miso   out  1   responder-out data
//  mem_req    out  1   word fetch request; held high until mem_ack
//  mem_addr   out  24  word-aligned byte address ({addr[23:2],2'b00}), stable while mem_req
//  mem_ack    in   1   one-cycle completion; mem_rdata valid same cycle
//  mem_rdata  in   32  little-endian word: byte at mem_addr+0 = mem_rdata[7:0]
//  busy       out  1   high while synced SS low
//  underrun   out  1   one-cycle pulse when a word boundary arrives with no fetched word
// BEHAVIOUR
//  Reset: spi_miso=1, mem_req=0, mem_addr=0, busy=0, underrun=0, state IDLE, bit counter 0, buffers invalid.
//  Edge detect on synced SCK: rise = sampling edge, fall = MISO update edge. Master requirement:
//   SCK high and low phases each >= SYNC_STAGES+3 clocks; MISO changes <= SYNC_STAGES+2 clocks after real SCK fall.
//  States:
//   IDLE   : SS high; spi_miso=1. SS low -> CMD, counter=0.
//   CMD    : shift MOSI on 8 rises. 8th bit: opcode==CMD_READ -> ADDR, else -> IGNORE.
//   ADDR   : shift 24 bits. On 24th rise: mem_req=1 next cycle, mem_addr={addr[23:2],2'b00}; -> DATA.
//            addr[1:0] are ignored (word-aligned reads only).
//   DATA   : on each fall, shift out one bit. Byte order: rdata[7:0],[15:8],[23:16],[31:24]; each byte MSB first.
//            First fall after entering DATA loads the current word into the shifter.
//            On every word load: issue prefetch for mem_addr+4 (wrap at 2**ADDR_W).
//            Word load with no valid fetched word -> underrun pulse, shifter=0, MISO=0 for that word.
//   IGNORE : spi_miso=1, no mem_req, until SS high.
//  spi_miso is 1 in IDLE/CMD/ADDR/IGNORE.
//  SS high (synced) from any state -> IDLE next cycle: spi_miso=1, counters cleared, buffers invalid.
//   An outstanding mem_req stays high until mem_ack; that returned data is discarded.
//   A new transaction may start meanwhile; its first req is issued only after the stale ack.
//  mem_ack without mem_req is ignored. mem_ack and SS rise in the same cycle: data discarded.
//  SCK edges while SS high are ignored. Max one outstanding request; at most one buffered word.
//  Reset mid-transfer: immediate return to reset values; the in-flight request is abandoned.
// TESTING
//  1 reset low -> spi_miso=1, mem_req=0, busy=0, underrun=0; hold 10 SCK pulses with SS high -> no change.
//  2 cmd 03, addr 0x000104, ack 2 clk later with 0x44332211 -> mem_addr=0x000104; MISO bytes 11,22,33,44.
//  3 same as 2, 64 data clocks, 2nd word 0x88776655 -> 2nd req mem_addr=0x000108; MISO 55,66,77,88; no underrun.
//  4 cmd 0x9F + 32 SCK -> no mem_req; spi_miso stays 1; SS high -> IDLE; next cmd 03 read succeeds.
//  5 addr 0xFFFFFC, 64 data clocks -> prefetch mem_addr=0x000000; SS high after 12 addr bits -> no req, IDLE.
//  6 mem_ack withheld past 1st data fall -> underrun=1 one cycle, MISO=0 for 32 bits; reset low mid-DATA -> reset values.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI-flash READ responder (mode 0, MSB-first): oversamples the SPI pins, decodes 0x03 + address,
// fetches little-endian words over a req/ack port and streams them out on MISO with one-word prefetch.
module spi_flash_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter int         ADDR_W      = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              underrun
);

  localparam int CNT_W = (ADDR_W > 32) ? $clog2(ADDR_W) : 5;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] ss_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sck_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sck_prev_reg;
  logic                   sck_rise;
  logic                   sck_fall;

  state_t            state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [ADDR_W-1:0] shift_in_reg;
  logic [ADDR_W-1:0] shift_in_next;
  logic [31:0]       shift_out_reg;
  logic [31:0]       buf_reg;
  logic              buf_valid_reg;
  logic              stale_reg;
  logic              want_reg;
  logic [ADDR_W-1:0] want_addr_reg;

  logic [31:0]       load_word;
  logic              load_now;
  logic              issue_now;
  logic              req_free;
  logic [ADDR_W-1:0] issue_addr;

  // SS synchronizer resets to "deselected" so busy is low out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_sync_reg  <= '0;
      ss_sync_reg   <= '1;
      mosi_sync_reg <= '0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], spi_ss};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
  assign ss_s   = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
  assign busy   = ~ss_s;

  always_comb begin
    sck_rise      = sck_s & ~sck_prev_reg;
    sck_fall      = ~sck_s & sck_prev_reg;
    shift_in_next = {shift_in_reg[ADDR_W-2:0], mosi_s};
    load_now      = !ss_s && (state_reg == DATA) && sck_fall && (bit_cnt_reg == '0);
    // Byte 0 goes out first, each byte MSB first.
    load_word     = buf_valid_reg ? {buf_reg[7:0], buf_reg[15:8], buf_reg[23:16], buf_reg[31:24]} : 32'h0;
    req_free      = !mem_req || mem_ack;
    issue_now     = 1'b0;
    issue_addr    = mem_addr + ADDR_W'(4);
    if (!ss_s && (state_reg == ADDR) && sck_rise && (bit_cnt_reg == CNT_W'(ADDR_W-1))) begin
      issue_now  = 1'b1;
      issue_addr = {shift_in_next[ADDR_W-1:2], 2'b00};
    end else if (load_now && (buf_valid_reg || (!mem_req && !want_reg))) begin
      // After an underrun with a fetch still in flight, that fetch fills the next slot instead.
      issue_now = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_in_reg  <= '0;
      shift_out_reg <= '0;
      buf_reg       <= '0;
      buf_valid_reg <= 1'b0;
      stale_reg     <= 1'b0;
      want_reg      <= 1'b0;
      want_addr_reg <= '0;
      sck_prev_reg  <= 1'b0;
      spi_miso      <= 1'b1;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      underrun      <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;
      underrun     <= 1'b0;

      if (mem_req && mem_ack) begin
        mem_req   <= 1'b0;
        stale_reg <= 1'b0;
        if (!stale_reg && !ss_s) begin
          buf_reg       <= mem_rdata;
          buf_valid_reg <= 1'b1;
        end
      end

      // A request that finds the port busy (stale fetch outstanding) is parked until it frees.
      if (issue_now) begin
        if (req_free) begin
          mem_req  <= 1'b1;
          mem_addr <= issue_addr;
        end else begin
          want_reg      <= 1'b1;
          want_addr_reg <= issue_addr;
        end
      end else if (want_reg && req_free && !ss_s) begin
        mem_req  <= 1'b1;
        mem_addr <= want_addr_reg;
        want_reg <= 1'b0;
      end

      if (ss_s) begin
        state_reg     <= IDLE;
        spi_miso      <= 1'b1;
        bit_cnt_reg   <= '0;
        buf_valid_reg <= 1'b0;
        want_reg      <= 1'b0;
        if (mem_req && !mem_ack) begin
          stale_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= CMD;
            bit_cnt_reg <= '0;
            spi_miso    <= 1'b1;
          end
          CMD: begin
            if (sck_rise) begin
              shift_in_reg <= shift_in_next;
              if (bit_cnt_reg == CNT_W'(7)) begin
                bit_cnt_reg <= '0;
                state_reg   <= (shift_in_next[7:0] == CMD_READ) ? ADDR : IGNORE;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              shift_in_reg <= shift_in_next;
              if (bit_cnt_reg == CNT_W'(ADDR_W-1)) begin
                bit_cnt_reg <= '0;
                state_reg   <= DATA;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (sck_fall) begin
              if (load_now) begin
                spi_miso      <= load_word[31];
                shift_out_reg <= {load_word[30:0], 1'b0};
                if (buf_valid_reg) begin
                  buf_valid_reg <= 1'b0;
                end else begin
                  underrun <= 1'b1;
                end
              end else begin
                spi_miso      <= shift_out_reg[31];
                shift_out_reg <= {shift_out_reg[30:0], 1'b0};
              end
              bit_cnt_reg <= (bit_cnt_reg == CNT_W'(31)) ? '0 : bit_cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            spi_miso <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
